// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, memory-stage FSM states and
// exception cause codes also used by the exception unit.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Cause codes as they appear in the CP0 Cause.ExcCode field
    localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CODE_ADES = 5'd5;
    localparam logic [4:0] EXC_CODE_OV   = 5'd12;

    // Word accesses must have the two low address bits clear
    function automatic logic misaligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/memory_access.sv
// Memory-access pipeline stage: registers the execute-stage result, runs word
// loads/stores over a req/ack data-memory port, and emits one write-back
// record (with address-error / overflow flags) per retired instruction.
module memory_access
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [WORD_W-1:0] ALUresult,
    input  logic [WORD_W-1:0] StoreData,
    input  logic [REG_W-1:0]  WriteReg,
    input  logic              overFlow,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic              RegWrite,
    input  logic              OvfCheck,

    output logic              dm_req,
    output logic              dm_we,
    output logic [WORD_W-1:0] dm_addr,
    output logic [WORD_W-1:0] dm_wdata,
    input  logic [WORD_W-1:0] dm_rdata,
    input  logic              dm_ack,

    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [REG_W-1:0]  wb_reg,
    output logic [WORD_W-1:0] wb_data,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              exc_ovf
);

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic              is_mem;
    logic              bad_addr;
    logic              ovf_trap;
    logic [REG_W-1:0]  pend_reg;
    logic              pend_regwrite;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready;
    assign is_mem   = MemRead | MemWrite;
    assign bad_addr = misaligned(ALUresult);
    assign ovf_trap = OvfCheck & overFlow;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: only an aligned access leaves IDLE; the ack returns to it
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && is_mem && !bad_addr) next_state = WAIT;
            WAIT: if (dm_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory request, pending write-back info and the write-back record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_wdata      <= '0;
            pend_reg      <= '0;
            pend_regwrite <= 1'b0;
            wb_valid      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_reg        <= '0;
            wb_data       <= '0;
            exc_adel      <= 1'b0;
            exc_ades      <= 1'b0;
            exc_ovf       <= 1'b0;
        end else begin
            // Write-back fields are zero unless a record is being presented
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
            exc_adel    <= 1'b0;
            exc_ades    <= 1'b0;
            exc_ovf     <= 1'b0;

            if (state == IDLE && accept) begin
                if (!is_mem) begin
                    wb_valid    <= 1'b1;
                    wb_regwrite <= RegWrite & ~ovf_trap;
                    wb_reg      <= WriteReg;
                    wb_data     <= ALUresult;
                    exc_ovf     <= ovf_trap & RegWrite;
                end else if (bad_addr) begin
                    // Faulting address goes out on wb_data for BadVAddr
                    wb_valid    <= 1'b1;
                    wb_reg      <= WriteReg;
                    wb_data     <= ALUresult;
                    exc_ades    <= MemWrite;
                    exc_adel    <= ~MemWrite;
                end else begin
                    // MemRead together with MemWrite is handled as a store
                    dm_req        <= 1'b1;
                    dm_we         <= MemWrite;
                    dm_addr       <= ALUresult;
                    dm_wdata      <= StoreData;
                    pend_reg      <= WriteReg;
                    pend_regwrite <= ~MemWrite & RegWrite & MemToReg;
                end
            end else if (state == WAIT && dm_ack) begin
                dm_req      <= 1'b0;
                dm_we       <= 1'b0;
                wb_valid    <= 1'b1;
                wb_regwrite <= pend_regwrite;
                wb_reg      <= pend_reg;
                wb_data     <= dm_we ? '0 : dm_rdata;
            end
        end
    end

endmodule
